// File: rtl/fwd_pkg.sv
// fwd_pkg: shared widths, select-code type and clog2 helper for the operand-forwarding stage.
package fwd_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_SRC_DEF = 2;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    // Select codes: 0 = register file, i+1 = forwarding source i.
    localparam int SEL_W = clog2(NUM_SRC_DEF + 1);
    typedef logic [SEL_W-1:0] fwd_sel_t;
    localparam fwd_sel_t SEL_RF = '0;
endpackage

// File: rtl/fwd_if.sv
// fwd_if: request/writer inputs and registered-operand outputs of the forwarding stage.
interface fwd_if #(
    parameter int DATA_W  = fwd_pkg::DATA_W_DEF,
    parameter int ADDR_W  = fwd_pkg::ADDR_W_DEF,
    parameter int NUM_SRC = fwd_pkg::NUM_SRC_DEF
);
    import fwd_pkg::*;
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_W-1:0]         rs_addr;
    logic [ADDR_W-1:0]         rt_addr;
    logic [DATA_W-1:0]         rs_data;
    logic [DATA_W-1:0]         rt_data;
    logic [NUM_SRC-1:0]        wr_en;
    logic [NUM_SRC-1:0]        wr_pend;
    logic [NUM_SRC*ADDR_W-1:0] wr_addr;
    logic [NUM_SRC*DATA_W-1:0] wr_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         opA;
    logic [DATA_W-1:0]         opB;
    fwd_sel_t                  selA;
    fwd_sel_t                  selB;
    modport master (
        output in_valid, rs_addr, rt_addr, rs_data, rt_data, wr_en, wr_pend, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, opA, opB, selA, selB
    );
    modport slave (
        input  in_valid, rs_addr, rt_addr, rs_data, rt_data, wr_en, wr_pend, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, opA, opB, selA, selB
    );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: combinational priority matcher for one operand; lowest-index matching writer wins.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         rfData,
    input  logic [NUM_SRC-1:0]        wrEn,
    input  logic [NUM_SRC-1:0]        wrPend,
    input  logic [NUM_SRC*ADDR_W-1:0] wrAddr,
    input  logic [NUM_SRC*DATA_W-1:0] wrData,
    output fwd_sel_t                  sel,
    output logic [DATA_W-1:0]         data,
    output logic                      pend
);
    // Scan oldest to youngest so the youngest match overwrites; r0 is never forwarded.
    always_comb begin
        sel = SEL_RF;
        data = rfData;
        pend = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (wrEn[i] && wrAddr[i*ADDR_W +: ADDR_W] == addr && addr != '0) begin
                sel = fwd_sel_t'(i + 1);
                data = wrData[i*DATA_W +: DATA_W];
                pend = wrPend[i];
            end
        end
    end
endmodule

// File: rtl/fwd_operand_stage.sv
// fwd_operand_stage: forwards both ALU operands, stalls on load-use, registers them behind valid/ready.
// Optional FWD_STATS_EN adds saturating fwd_cnt / stall_cnt outputs.
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    fwd_if.slave        bus
`ifdef FWD_STATS_EN
    ,
    output logic [15:0] fwd_cnt,
    output logic [15:0] stall_cnt
`endif
);
    fwd_sel_t          nxtSelA, nxtSelB;
    logic [DATA_W-1:0] nxtA, nxtB;
    logic              pendA, pendB, hazard, capture;
    fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) selRs (
        .addr(bus.rs_addr), .rfData(bus.rs_data), .wrEn(bus.wr_en), .wrPend(bus.wr_pend),
        .wrAddr(bus.wr_addr), .wrData(bus.wr_data), .sel(nxtSelA), .data(nxtA), .pend(pendA)
    );
    fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) selRt (
        .addr(bus.rt_addr), .rfData(bus.rt_data), .wrEn(bus.wr_en), .wrPend(bus.wr_pend),
        .wrAddr(bus.wr_addr), .wrData(bus.wr_data), .sel(nxtSelB), .data(nxtB), .pend(pendB)
    );
    assign hazard = pendA || pendB;
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
    assign capture = bus.in_valid && bus.in_ready;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus.out_valid <= 1'b0;
            bus.opA <= '0;
            bus.opB <= '0;
            bus.selA <= SEL_RF;
            bus.selB <= SEL_RF;
        end else if (capture) begin
            bus.out_valid <= 1'b1;
            bus.opA <= nxtA;
            bus.opB <= nxtB;
            bus.selA <= nxtSelA;
            bus.selB <= nxtSelB;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
`ifdef FWD_STATS_EN
    logic [1:0]  fwdInc;
    logic [16:0] fwdSum;
    assign fwdInc = capture ? {1'b0, nxtSelA != SEL_RF} + {1'b0, nxtSelB != SEL_RF} : 2'd0;
    assign fwdSum = {1'b0, fwd_cnt} + {15'd0, fwdInc};
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fwd_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            fwd_cnt <= fwdSum[16] ? 16'hFFFF : fwdSum[15:0];
            if (bus.in_valid && hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fwd_operand_stage.sv
// tb_fwd_operand_stage: directed vectors into a scoreboard queue; a negedge monitor pops on each handshake.
module tb_fwd_operand_stage;
    import fwd_pkg::*;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        fwd_sel_t      sa;
        fwd_sel_t      sb;
    } item_t;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int total = 0;
    int bad = 0;
    int w;
    item_t expQ[$];
    always #5 Clk = ~Clk;
    fwd_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS)) bus ();
`ifdef FWD_STATS_EN
    logic [15:0] fwdCnt, stallCnt;
`endif
    fwd_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt(fwdCnt),
        .stall_cnt(stallCnt)
`endif
    );
    function automatic item_t mk(logic [DW-1:0] a, logic [DW-1:0] b, fwd_sel_t sa, fwd_sel_t sb);
        return {a, b, sa, sb};
    endfunction
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic setReq(logic [AW-1:0] rs, logic [AW-1:0] rt, logic [DW-1:0] rsd, logic [DW-1:0] rtd,
                          logic [NS-1:0] en, logic [NS-1:0] pend, logic [AW-1:0] a0, logic [AW-1:0] a1,
                          logic [DW-1:0] d0, logic [DW-1:0] d1);
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        bus.rs_data = rsd;
        bus.rt_data = rtd;
        bus.wr_en = en;
        bus.wr_pend = pend;
        bus.wr_addr = {a1, a0};
        bus.wr_data = {d1, d0};
        bus.in_valid = 1'b1;
    endtask
    // Waits (bounded) for in_ready, records the expected output, returns just after the capture edge.
    task automatic issue(string name, item_t e, output int waited);
        waited = 0;
        @(negedge Clk);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge Clk);
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL %s: in_ready never rose, got 0 expected 1", name);
        end else expQ.push_back(e);
        @(posedge Clk);
        #1;
    endtask
    always @(negedge Clk) begin
        item_t got, e;
        if (!Rst && bus.out_valid && bus.out_ready) begin
            got = {bus.opA, bus.opB, bus.selA, bus.selB};
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got %h expected none", got);
            end else begin
                e = expQ.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL out_data: got %h expected %h", got, e);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        setReq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_opA", 64'(bus.opA), 0);
        check("rst_opB", 64'(bus.opB), 0);
        check("rst_selA", 64'(bus.selA), 0);
        check("rst_selB", 64'(bus.selB), 0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        setReq(3, 4, 'h11, 'h22, 2'b00, 2'b00, 0, 0, 0, 0);
        issue("nomatch", mk('h11, 'h22, 0, 0), w);
        setReq(5, 5, 'h1, 'h2, 2'b11, 2'b00, 5, 5, 'hAAAA, 'hBBBB);
        issue("priority", mk('hAAAA, 'hAAAA, 1, 1), w);
        check("b2b_waited", 64'(w), 0);
        setReq(9, 6, 'h1, 'h2, 2'b11, 2'b00, 9, 6, 'hC0, 'hC1);
        issue("split", mk('hC0, 'hC1, 1, 2), w);
        setReq(0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 'hDEAD, 0);
        issue("r0guard", mk(0, 0, 0, 0), w);
        setReq(8, 8, 'h1, 'h2, 2'b11, 2'b10, 8, 8, 'h80, 'h81);
        issue("olderpend", mk('h80, 'h80, 1, 1), w);
        check("olderpend_waited", 64'(w), 0);
        setReq(7, 4, 0, 'h44, 2'b01, 2'b01, 7, 0, 'h7777, 0);
        @(negedge Clk);
        check("loaduse_in_ready", 64'(bus.in_ready), 0);
        @(posedge Clk);
        #1 bus.wr_pend = 2'b00;
        issue("loaduse", mk('h7777, 'h44, 1, 0), w);
        check("loaduse_waited", 64'(w), 0);
`ifdef FWD_STATS_EN
        check("stall_cnt", 64'(stallCnt), 1);
        check("fwd_cnt", 64'(fwdCnt), 7);
`endif
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        bus.out_ready = 1'b0;
        setReq(10, 11, 'hA1, 'hB1, 2'b00, 2'b00, 0, 0, 0, 0);
        issue("bp_first", mk('hA1, 'hB1, 0, 0), w);
        setReq(12, 13, 'hA2, 'hB2, 2'b00, 2'b00, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge Clk);
            check("bp_in_ready", 64'(bus.in_ready), 0);
            check("bp_out_valid", 64'(bus.out_valid), 1);
            check("bp_hold", {bus.opA, bus.opB}, {32'hA1, 32'hB1});
        end
        @(posedge Clk);
        #1 bus.out_ready = 1'b1;
        issue("bp_release", mk('hA2, 'hB2, 0, 0), w);
        check("bp_release_waited", 64'(w), 0);
        bus.in_valid = 1'b0;
        @(posedge Clk);
        #1 bus.out_ready = 1'b0;
        setReq(14, 15, 'hA3, 'hB3, 2'b00, 2'b00, 0, 0, 0, 0);
        issue("hold_for_rst", mk('hA3, 'hB3, 0, 0), w);
        bus.in_valid = 1'b0;
        @(negedge Clk);
        #2 Rst = 1'b1;
        expQ.delete();
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 0);
        check("async_rst_opA", 64'(bus.opA), 0);
        check("async_rst_selA", 64'(bus.selA), 0);
`ifdef FWD_STATS_EN
        check("async_rst_fwd_cnt", 64'(fwdCnt), 0);
`endif
        @(posedge Clk);
        #1 Rst = 1'b0;
        bus.out_ready = 1'b1;
        setReq(3, 4, 'h11, 'h22, 2'b00, 2'b00, 0, 0, 0, 0);
        issue("after_rst", mk('h11, 'h22, 0, 0), w);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("queue_empty", 64'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
